// File: rtl/n101_uartpad_pkg.sv
// Shared constants, defaults and the pad-control bundle for the UART pad port.
// Flow-control logic elsewhere is gated by N101_UARTPAD_FLOWCTRL_EN.
package n101_uartpad_pkg;

  localparam logic IDLE_LVL = 1'b1;

  localparam int   CHANNELS_DEF     = 2;
  localparam int   FILT_CYCLES_DEF  = 4;
  localparam int   BREAK_CYCLES_DEF = 160;
  localparam logic DRIVE_DEF        = 1'b0;

  typedef struct packed {
    logic oval;
    logic oe;
    logic ie;
    logic pue;
    logic ds;
  } pad_ctrl_t;

  localparam pad_ctrl_t RX_PAD_RST = '{oval: 1'b0, oe: 1'b0, ie: 1'b0, pue: 1'b1, ds: 1'b0};
  localparam pad_ctrl_t TX_PAD_RST = '{oval: IDLE_LVL, oe: 1'b0, ie: 1'b0, pue: 1'b0, ds: 1'b0};

  // Input-direction pad (RXD, CTS): pulled up, receiver enabled with the channel.
  function automatic pad_ctrl_t in_pad(input logic en, input logic drive);
    pad_ctrl_t p;
    p    = RX_PAD_RST;
    p.ie = en;
    p.ds = drive;
    return p;
  endfunction

  function automatic pad_ctrl_t out_pad(input logic en, input logic lvl, input logic drive);
    pad_ctrl_t p;
    p      = TX_PAD_RST;
    p.oval = lvl;
    p.oe   = en;
    p.ds   = drive;
    return p;
  endfunction

endpackage

// File: rtl/n101_uartpad_rxfilt.sv
// Per-channel RX conditioning: 2-flop synchroniser, glitch filter and break counter.
// The filter and break state are held idle while the channel is disabled.
module n101_uartpad_rxfilt
  import n101_uartpad_pkg::*;
#(
  parameter int FILT_CYCLES  = FILT_CYCLES_DEF,
  parameter int BREAK_CYCLES = BREAK_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic loop,
  input  logic txd,
  input  logic pad_rxd,
  output logic rxd,
  output logic rx_break
);

  localparam int              BW        = $clog2(BREAK_CYCLES + 1);
  localparam logic [7:0]      FILT_LAST = 8'(FILT_CYCLES - 1);
  localparam logic [BW-1:0]   BRK_MAX   = BW'(BREAK_CYCLES);

  logic          sync_p0;
  logic          sync_p1;
  logic          filt_in;
  logic          filt_p2;
  logic [7:0]    cnt;
  logic [BW-1:0] bcnt;

  // Stage p0/p1: synchroniser, free-running regardless of enable
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_p0 <= IDLE_LVL;
      sync_p1 <= IDLE_LVL;
    end else begin
      sync_p0 <= pad_rxd;
      sync_p1 <= sync_p0;
    end
  end

  assign filt_in = loop ? txd : sync_p1;

  // Stage p2: filtered level and break counter
  always_ff @(posedge clock) begin
    if (!reset || !en) begin
      filt_p2 <= IDLE_LVL;
      cnt     <= '0;
      bcnt    <= '0;
    end else begin
      if (filt_in == filt_p2) begin
        cnt <= '0;
      end else if (cnt == FILT_LAST) begin
        filt_p2 <= ~filt_p2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end

      if (filt_p2) begin
        bcnt <= '0;
      end else if (bcnt != BRK_MAX) begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // Gate with en so a disable shows idle on the very cycle en_q drops.
  assign rxd      = filt_p2 | ~en;
  assign rx_break = en & (bcnt == BRK_MAX);

endmodule

// File: rtl/n101_uartpadport.sv
// Multi-channel UART-to-pad port with RX filtering, break detect, enable and loopback.
// Optional RTS/CTS flow control: define N101_UARTPAD_FLOWCTRL_EN.
module n101_uartpadport
  import n101_uartpad_pkg::*;
#(
  parameter int   CHANNELS     = CHANNELS_DEF,
  parameter int   FILT_CYCLES  = FILT_CYCLES_DEF,
  parameter int   BREAK_CYCLES = BREAK_CYCLES_DEF,
  parameter logic DRIVE        = DRIVE_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] io_en,
  input  logic [CHANNELS-1:0] io_loopback,
  input  logic [CHANNELS-1:0] io_uart_txd,
  output logic [CHANNELS-1:0] io_uart_rxd,
  output logic [CHANNELS-1:0] io_rx_break,
  input  logic [CHANNELS-1:0] io_pins_rxd_i_ival,
  output logic [CHANNELS-1:0] io_pins_rxd_o_oval,
  output logic [CHANNELS-1:0] io_pins_rxd_o_oe,
  output logic [CHANNELS-1:0] io_pins_rxd_o_ie,
  output logic [CHANNELS-1:0] io_pins_rxd_o_pue,
  output logic [CHANNELS-1:0] io_pins_rxd_o_ds,
`ifdef N101_UARTPAD_FLOWCTRL_EN
  input  logic [CHANNELS-1:0] io_uart_rts_n,
  output logic [CHANNELS-1:0] io_uart_cts_n,
  input  logic [CHANNELS-1:0] io_pins_cts_i_ival,
  output logic [CHANNELS-1:0] io_pins_cts_o_oval,
  output logic [CHANNELS-1:0] io_pins_cts_o_oe,
  output logic [CHANNELS-1:0] io_pins_cts_o_ie,
  output logic [CHANNELS-1:0] io_pins_cts_o_pue,
  output logic [CHANNELS-1:0] io_pins_cts_o_ds,
  input  logic [CHANNELS-1:0] io_pins_rts_i_ival,
  output logic [CHANNELS-1:0] io_pins_rts_o_oval,
  output logic [CHANNELS-1:0] io_pins_rts_o_oe,
  output logic [CHANNELS-1:0] io_pins_rts_o_ie,
  output logic [CHANNELS-1:0] io_pins_rts_o_pue,
  output logic [CHANNELS-1:0] io_pins_rts_o_ds,
`endif
  input  logic [CHANNELS-1:0] io_pins_txd_i_ival,
  output logic [CHANNELS-1:0] io_pins_txd_o_oval,
  output logic [CHANNELS-1:0] io_pins_txd_o_oe,
  output logic [CHANNELS-1:0] io_pins_txd_o_ie,
  output logic [CHANNELS-1:0] io_pins_txd_o_pue,
  output logic [CHANNELS-1:0] io_pins_txd_o_ds
);

  logic [CHANNELS-1:0] en_q;
  logic [CHANNELS-1:0] loop_q;
  logic [CHANNELS-1:0] txd_q;
  pad_ctrl_t           rx_pad_q [CHANNELS];
  pad_ctrl_t           tx_pad_q [CHANNELS];
  logic                unused_txd_ival;

  assign unused_txd_ival = ^io_pins_txd_i_ival;

  // Pad controls are computed from the raw inputs so they match en_q/txd_q in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      en_q   <= '0;
      loop_q <= '0;
      txd_q  <= {CHANNELS{IDLE_LVL}};
      for (int i = 0; i < CHANNELS; i++) begin
        rx_pad_q[i] <= in_pad(1'b0, DRIVE);
        tx_pad_q[i] <= out_pad(1'b0, IDLE_LVL, DRIVE);
      end
    end else begin
      en_q   <= io_en;
      loop_q <= io_loopback;
      txd_q  <= io_uart_txd;
      for (int i = 0; i < CHANNELS; i++) begin
        rx_pad_q[i] <= in_pad(io_en[i], DRIVE);
        tx_pad_q[i] <= out_pad(io_en[i],
                               (io_en[i] & ~io_loopback[i]) ? io_uart_txd[i] : IDLE_LVL,
                               DRIVE);
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    n101_uartpad_rxfilt #(
      .FILT_CYCLES  (FILT_CYCLES),
      .BREAK_CYCLES (BREAK_CYCLES)
    ) u_rxfilt (
      .clock    (clock),
      .reset    (reset),
      .en       (en_q[g]),
      .loop     (loop_q[g]),
      .txd      (txd_q[g]),
      .pad_rxd  (io_pins_rxd_i_ival[g]),
      .rxd      (io_uart_rxd[g]),
      .rx_break (io_rx_break[g])
    );

    assign io_pins_rxd_o_oval[g] = rx_pad_q[g].oval;
    assign io_pins_rxd_o_oe[g]   = rx_pad_q[g].oe;
    assign io_pins_rxd_o_ie[g]   = rx_pad_q[g].ie;
    assign io_pins_rxd_o_pue[g]  = rx_pad_q[g].pue;
    assign io_pins_rxd_o_ds[g]   = rx_pad_q[g].ds;

    assign io_pins_txd_o_oval[g] = tx_pad_q[g].oval;
    assign io_pins_txd_o_oe[g]   = tx_pad_q[g].oe;
    assign io_pins_txd_o_ie[g]   = tx_pad_q[g].ie;
    assign io_pins_txd_o_pue[g]  = tx_pad_q[g].pue;
    assign io_pins_txd_o_ds[g]   = tx_pad_q[g].ds;
  end

`ifdef N101_UARTPAD_FLOWCTRL_EN
  logic [CHANNELS-1:0] rts_q;
  logic [CHANNELS-1:0] cts_p0;
  logic [CHANNELS-1:0] cts_p1;
  pad_ctrl_t           cts_pad_q [CHANNELS];
  pad_ctrl_t           rts_pad_q [CHANNELS];
  logic                unused_rts_ival;

  assign unused_rts_ival = ^io_pins_rts_i_ival;

  // Stage p0/p1: CTS synchroniser alongside the registered RTS level
  always_ff @(posedge clock) begin
    if (!reset) begin
      rts_q  <= {CHANNELS{IDLE_LVL}};
      cts_p0 <= {CHANNELS{IDLE_LVL}};
      cts_p1 <= {CHANNELS{IDLE_LVL}};
      for (int i = 0; i < CHANNELS; i++) begin
        cts_pad_q[i] <= in_pad(1'b0, DRIVE);
        rts_pad_q[i] <= out_pad(1'b0, IDLE_LVL, DRIVE);
      end
    end else begin
      rts_q  <= io_uart_rts_n;
      cts_p0 <= io_pins_cts_i_ival;
      cts_p1 <= cts_p0;
      for (int i = 0; i < CHANNELS; i++) begin
        cts_pad_q[i] <= in_pad(io_en[i], DRIVE);
        rts_pad_q[i] <= out_pad(io_en[i],
                                (io_en[i] & ~io_loopback[i]) ? io_uart_rts_n[i] : IDLE_LVL,
                                DRIVE);
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_fc
    assign io_uart_cts_n[g] = en_q[g] ? (loop_q[g] ? rts_q[g] : cts_p1[g]) : IDLE_LVL;

    assign io_pins_cts_o_oval[g] = cts_pad_q[g].oval;
    assign io_pins_cts_o_oe[g]   = cts_pad_q[g].oe;
    assign io_pins_cts_o_ie[g]   = cts_pad_q[g].ie;
    assign io_pins_cts_o_pue[g]  = cts_pad_q[g].pue;
    assign io_pins_cts_o_ds[g]   = cts_pad_q[g].ds;

    assign io_pins_rts_o_oval[g] = rts_pad_q[g].oval;
    assign io_pins_rts_o_oe[g]   = rts_pad_q[g].oe;
    assign io_pins_rts_o_ie[g]   = rts_pad_q[g].ie;
    assign io_pins_rts_o_pue[g]  = rts_pad_q[g].pue;
    assign io_pins_rts_o_ds[g]   = rts_pad_q[g].ds;
  end
`endif

endmodule

// File: tb/tb_n101_uartpadport.sv
// Bench for n101_uartpadport (default build): table vectors plus timed corner sequences,
// with expectations queued as stimulus is driven and checked on the falling edge.
module tb_n101_uartpadport;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] io_en, io_loopback, io_uart_txd, io_uart_rxd, io_rx_break;
  logic [1:0] io_pins_rxd_i_ival, io_pins_txd_i_ival;
  logic [1:0] rxd_oval, rxd_oe, rxd_ie, rxd_pue, rxd_ds;
  logic [1:0] txd_oval, txd_oe, txd_ie, txd_pue, txd_ds;

  always #5 clock = ~clock;

  n101_uartpadport #(
    .CHANNELS(2), .FILT_CYCLES(4), .BREAK_CYCLES(160), .DRIVE(1'b0)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .io_en              (io_en),
    .io_loopback        (io_loopback),
    .io_uart_txd        (io_uart_txd),
    .io_uart_rxd        (io_uart_rxd),
    .io_rx_break        (io_rx_break),
    .io_pins_rxd_i_ival (io_pins_rxd_i_ival),
    .io_pins_rxd_o_oval (rxd_oval),
    .io_pins_rxd_o_oe   (rxd_oe),
    .io_pins_rxd_o_ie   (rxd_ie),
    .io_pins_rxd_o_pue  (rxd_pue),
    .io_pins_rxd_o_ds   (rxd_ds),
    .io_pins_txd_i_ival (io_pins_txd_i_ival),
    .io_pins_txd_o_oval (txd_oval),
    .io_pins_txd_o_oe   (txd_oe),
    .io_pins_txd_o_ie   (txd_ie),
    .io_pins_txd_o_pue  (txd_pue),
    .io_pins_txd_o_ds   (txd_ds)
  );

  // Signal codes used by the scoreboard.
  localparam int S_RXD = 0, S_BRK = 1, S_TOVAL = 2, S_TOE = 3, S_TIE = 4, S_TPUE = 5,
                 S_TDS = 6, S_ROVAL = 7, S_ROE = 8, S_RIE = 9, S_RPUE = 10, S_RDS = 11;

  typedef struct {
    int    due;
    string name;
    int    sig;
    int    ch;
    logic  val;
  } exp_t;

  typedef struct {
    string      name;
    logic [1:0] en, loop, txd, pad;
    int         hold;
    logic [1:0] rxd, brk, oe, oval, ie;
  } vec_t;

  exp_t sbq[$];
  exp_t keep[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic act;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic sample(input int sig, input int ch);
    case (sig)
      S_RXD:   return io_uart_rxd[ch];
      S_BRK:   return io_rx_break[ch];
      S_TOVAL: return txd_oval[ch];
      S_TOE:   return txd_oe[ch];
      S_TIE:   return txd_ie[ch];
      S_TPUE:  return txd_pue[ch];
      S_TDS:   return txd_ds[ch];
      S_ROVAL: return rxd_oval[ch];
      S_ROE:   return rxd_oe[ch];
      S_RIE:   return rxd_ie[ch];
      S_RPUE:  return rxd_pue[ch];
      default: return rxd_ds[ch];
    endcase
  endfunction

  always @(negedge clock) begin
    keep = {};
    foreach (sbq[i]) begin
      if (sbq[i].due == cyc) begin
        act = sample(sbq[i].sig, sbq[i].ch);
        total++;
        if (act !== sbq[i].val) begin
          bad++;
          $display("FAIL %s ch%0d sig%0d cyc=%0d: got %b expected %b",
                   sbq[i].name, sbq[i].ch, sbq[i].sig, cyc, act, sbq[i].val);
        end
      end else begin
        keep.push_back(sbq[i]);
      end
    end
    sbq = keep;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_at(input int due, input string name, input int sig, input int ch,
                           input logic val);
    exp_t e;
    e.due = due; e.name = name; e.sig = sig; e.ch = ch; e.val = val;
    sbq.push_back(e);
  endtask

  vec_t vt[6];
  int   t;
  logic [11:0] rst_exp;

  initial begin
    reset              = 1'b0;
    io_en              = 2'b11;
    io_loopback        = 2'b00;
    io_uart_txd        = 2'b00;
    io_pins_rxd_i_ival = 2'b00;
    io_pins_txd_i_ival = 2'b00;

    vt[0] = '{"enable",   2'b11, 2'b00, 2'b11, 2'b11, 1, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11};
    vt[1] = '{"txd_10",   2'b11, 2'b00, 2'b10, 2'b11, 1, 2'b11, 2'b00, 2'b11, 2'b10, 2'b11};
    vt[2] = '{"txd_01",   2'b11, 2'b00, 2'b01, 2'b11, 1, 2'b11, 2'b00, 2'b11, 2'b01, 2'b11};
    vt[3] = '{"dis_ch1",  2'b01, 2'b00, 2'b00, 2'b11, 1, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01};
    vt[4] = '{"loop_ch1", 2'b11, 2'b10, 2'b00, 2'b11, 1, 2'b11, 2'b00, 2'b11, 2'b10, 2'b11};
    vt[5] = '{"idle",     2'b11, 2'b00, 2'b11, 2'b11, 6, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11};

    // Reset values dominate active inputs; bit index = signal code.
    step(3);
    total++;
    if (io_uart_rxd !== 2'b11) begin
      bad++;
      $display("FAIL reset_direct rxd: got %b expected 11", io_uart_rxd);
    end
    total++;
    if (io_rx_break !== 2'b00) begin
      bad++;
      $display("FAIL reset_direct brk: got %b expected 00", io_rx_break);
    end
    total++;
    if (txd_oval !== 2'b11) begin
      bad++;
      $display("FAIL reset_direct txd_oval: got %b expected 11", txd_oval);
    end
    total++;
    if (txd_oe !== 2'b00) begin
      bad++;
      $display("FAIL reset_direct txd_oe: got %b expected 00", txd_oe);
    end
    total++;
    if (rxd_pue !== 2'b11) begin
      bad++;
      $display("FAIL reset_direct rxd_pue: got %b expected 11", rxd_pue);
    end
    rst_exp = 12'b0100_0000_0101;
    for (int ch = 0; ch < 2; ch++)
      for (int s = 0; s < 12; s++)
        expect_at(cyc, "reset_val", s, ch, rst_exp[s]);

    reset = 1'b1;
    for (int v = 0; v < 6; v++) begin
      io_en = vt[v].en; io_loopback = vt[v].loop;
      io_uart_txd = vt[v].txd; io_pins_rxd_i_ival = vt[v].pad;
      for (int ch = 0; ch < 2; ch++) begin
        expect_at(cyc + vt[v].hold, vt[v].name, S_RXD,   ch, vt[v].rxd[ch]);
        expect_at(cyc + vt[v].hold, vt[v].name, S_BRK,   ch, vt[v].brk[ch]);
        expect_at(cyc + vt[v].hold, vt[v].name, S_TOE,   ch, vt[v].oe[ch]);
        expect_at(cyc + vt[v].hold, vt[v].name, S_TOVAL, ch, vt[v].oval[ch]);
        expect_at(cyc + vt[v].hold, vt[v].name, S_RIE,   ch, vt[v].ie[ch]);
      end
      step(vt[v].hold);
    end

    // 3-cycle glitch on ch0 is rejected.
    io_pins_rxd_i_ival = 2'b10;
    for (int d = 1; d <= 10; d++) expect_at(cyc + d, "glitch3", S_RXD, 0, 1'b1);
    step(3);
    io_pins_rxd_i_ival = 2'b11;
    step(10);

    // 4-cycle pulse passes: falls 6 after pad edge, rises 6 after release.
    io_pins_rxd_i_ival = 2'b10;
    t = cyc;
    expect_at(t + 5,  "pulse4_pre",  S_RXD, 0, 1'b1);
    expect_at(t + 6,  "pulse4_fall", S_RXD, 0, 1'b0);
    expect_at(t + 9,  "pulse4_hold", S_RXD, 0, 1'b0);
    expect_at(t + 10, "pulse4_rise", S_RXD, 0, 1'b1);
    step(4);
    io_pins_rxd_i_ival = 2'b11;
    step(12);

    // Break: asserts 160 cycles after rxd falls, clears 1 after rxd rises.
    io_pins_rxd_i_ival = 2'b10;
    t = cyc;
    expect_at(t + 6,   "brk_fall",   S_RXD, 0, 1'b0);
    expect_at(t + 165, "brk_early",  S_BRK, 0, 1'b0);
    expect_at(t + 166, "brk_set",    S_BRK, 0, 1'b1);
    expect_at(t + 166, "brk_other",  S_BRK, 1, 1'b0);
    expect_at(t + 100, "rxd_other",  S_RXD, 1, 1'b1);
    step(170);
    io_pins_rxd_i_ival = 2'b11;
    t = cyc;
    expect_at(t + 5, "brk_rel_rxd0", S_RXD, 0, 1'b0);
    expect_at(t + 6, "brk_rel_rxd1", S_RXD, 0, 1'b1);
    expect_at(t + 6, "brk_hold",     S_BRK, 0, 1'b1);
    expect_at(t + 7, "brk_clear",    S_BRK, 0, 1'b0);
    step(10);

    // Loopback on ch1 with its pad held low; ch0 untouched.
    io_loopback = 2'b10; io_pins_rxd_i_ival = 2'b01;
    step(1);
    io_uart_txd = 2'b01;
    t = cyc;
    expect_at(t + 4, "lb_pre",   S_RXD, 1, 1'b1);
    expect_at(t + 5, "lb_fall",  S_RXD, 1, 1'b0);
    expect_at(t + 5, "lb_ch0",   S_RXD, 0, 1'b1);
    expect_at(t + 3, "lb_oval0", S_TOVAL, 0, 1'b1);
    for (int d = 1; d <= 5; d++) expect_at(t + d, "lb_oval1", S_TOVAL, 1, 1'b1);
    expect_at(t + 2, "lb_oe1",   S_TOE, 1, 1'b1);
    step(8);
    io_uart_txd = 2'b11;
    t = cyc;
    expect_at(t + 4, "lb_low",  S_RXD, 1, 1'b0);
    expect_at(t + 5, "lb_rise", S_RXD, 1, 1'b1);
    step(8);
    io_pins_rxd_i_ival = 2'b11;
    step(2);
    io_loopback = 2'b00;
    step(6);

    // Disable ch0 mid-break, then re-enable with pad still low.
    io_pins_rxd_i_ival = 2'b10;
    step(170);
    expect_at(cyc, "dis_pre_rxd", S_RXD, 0, 1'b0);
    expect_at(cyc, "dis_pre_brk", S_BRK, 0, 1'b1);
    io_en = 2'b10;
    expect_at(cyc + 1, "dis_rxd", S_RXD, 0, 1'b1);
    expect_at(cyc + 1, "dis_brk", S_BRK, 0, 1'b0);
    expect_at(cyc + 1, "dis_oe",  S_TOE, 0, 1'b0);
    expect_at(cyc + 1, "dis_ie",  S_RIE, 0, 1'b0);
    expect_at(cyc + 1, "dis_ch1", S_RXD, 1, 1'b1);
    step(5);
    io_en = 2'b11;
    t = cyc;
    expect_at(t + 1, "reen_oe",   S_TOE, 0, 1'b1);
    expect_at(t + 4, "reen_pre",  S_RXD, 0, 1'b1);
    expect_at(t + 5, "reen_fall", S_RXD, 0, 1'b0);
    step(8);
    io_pins_rxd_i_ival = 2'b11;
    step(10);

    // Reset mid-character forces reset values on the next edge.
    io_pins_rxd_i_ival = 2'b10;
    step(3);
    reset = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      expect_at(cyc + 1, "rst_mid_rxd",  S_RXD,   ch, 1'b1);
      expect_at(cyc + 1, "rst_mid_brk",  S_BRK,   ch, 1'b0);
      expect_at(cyc + 1, "rst_mid_oe",   S_TOE,   ch, 1'b0);
      expect_at(cyc + 1, "rst_mid_oval", S_TOVAL, ch, 1'b1);
      expect_at(cyc + 1, "rst_mid_ie",   S_RIE,   ch, 1'b0);
    end
    step(1);
    reset = 1'b1;
    io_pins_rxd_i_ival = 2'b11;
    step(10);

    for (int w = 0; w < 20 && sbq.size() != 0; w++) step(1);
    foreach (sbq[i]) begin
      total++;
      bad++;
      $display("FAIL %s ch%0d: expectation due at cyc=%0d never checked",
               sbq[i].name, sbq[i].ch, sbq[i].due);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/n101_uartpadport.md
# n101_uartpadport

Multi-channel UART-to-pad port: the parametrised successor of the single-channel UART/GPIO pad hookup. Each channel connects one UART's TXD/RXD to the GPIO pad I/O function (oval/oe/ie/pue/ds). Beyond plain pin wiring, each channel adds:

- a 2-flop RX synchroniser;
- a glitch filter;
- break detection;
- per-channel enable and internal loopback;
- optional RTS/CTS flow control.

It sits between the UART peripherals and the GPIO pad-mux in the perips subsystem.

## Interface
Parameters:
- CHANNELS, 2, number of UART channels (1..8)
- FILT_CYCLES, 4, consecutive stable cycles required before filtered RX changes (1..255)
- BREAK_CYCLES, 160, consecutive filtered-low cycles that flag a break (2..65535)
- DRIVE, 1'b0, value driven on every ds output

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-low reset
- io_en  in  CHANNELS  per-channel enable
- io_loopback  in  CHANNELS  per-channel internal loopback
- io_uart_txd  in  CHANNELS  UART transmit data
- io_uart_rxd  out  CHANNELS  filtered receive data to UART
- io_rx_break  out  CHANNELS  break-condition level
- io_pins_rxd_i_ival  in  CHANNELS  RX pad input
- io_pins_rxd_o_{oval,oe,ie,pue,ds}  out  CHANNELS each  RX pad controls
- io_pins_txd_i_ival  in  CHANNELS  TX pad input (unused)
- io_pins_txd_o_{oval,oe,ie,pue,ds}  out  CHANNELS each  TX pad controls
- Flow-control ports, present only with the Configuration macro:
  - io_uart_rts_n  in  CHANNELS
  - io_uart_cts_n  out  CHANNELS
  - io_pins_cts_i_ival  in  CHANNELS
  - io_pins_cts_o_*  out  CHANNELS each
  - io_pins_rts_i_ival  in  CHANNELS
  - io_pins_rts_o_*  out  CHANNELS each

## Operation
- All pad controls are registered.
  - RX pad: oval=0, oe=0, ie=en_q, pue=1, ds=DRIVE.
  - TX pad: oe=en_q, ie=0, pue=0, ds=DRIVE.
  - TX pad oval = (en_q & ~loop_q) ? txd_q : 1.
- Internal registers per channel: txd_q, en_q and loop_q, each capturing its input every cycle.
- RX path, per channel:
  - 2-flop synchroniser on io_pins_rxd_i_ival.
  - Filter input = loop_q ? txd_q : sync2.
- Glitch filter:
  - Counter cnt is 8 bits wide.
  - When filter input == filt, cnt clears to 0.
  - Otherwise cnt increments. When cnt reaches FILT_CYCLES-1, filt toggles and cnt clears on the same edge.
  - io_uart_rxd = filt.
- Break detection:
  - Counter bcnt has width clog2(BREAK_CYCLES+1).
  - It increments while filt=0 and saturates at BREAK_CYCLES.
  - It clears on the cycle filt=1.
  - io_rx_break = (bcnt == BREAK_CYCLES).
- Disable (en_q=0): the channel is held idle.
  - filt forced to 1; cnt and bcnt held at 0.
  - io_uart_rxd=1, io_rx_break=0.
  - The synchronisers keep running.
- Loopback:
  - The external RX pad is ignored.
  - The TX pad drives idle 1 (oe remains en_q).
- Simultaneous events:
  - Loopback and enable changes take effect via loop_q/en_q. No state is reset except as stated under Disable.
  - A loopback switch mid-character is handled purely by the filter.

## Timing
- Reset values for every channel:
  - io_uart_rxd=1, io_rx_break=0.
  - TX pad: oval=1, oe=0. RX pad: ie=0, pue=1.
  - All other pad o_* = 0, except ds=DRIVE.
  - cnt=0, bcnt=0, sync flops=1.
  - With flow control: cts_n=1.
- Latencies:
  - RX pad -> io_uart_rxd: 2 + FILT_CYCLES cycles.
  - Loopback txd -> io_uart_rxd: 1 + FILT_CYCLES cycles.
  - io_uart_txd -> TX pad oval: 1 cycle.
  - io_en -> pad oe/ie: 1 cycle.
- Break timing:
  - Break asserts exactly BREAK_CYCLES cycles after filt first falls.
  - It deasserts 1 cycle after filt rises.
- Glitch rejection: a pulse shorter than FILT_CYCLES cycles at sync2 never reaches io_uart_rxd.
- A reset asserted mid-character forces the reset values on the next edge.

## Configuration
- N101_UARTPAD_FLOWCTRL_EN defined:
  - Adds the RTS/CTS ports.
  - RTS pad: oval = registered io_uart_rts_n (1 when disabled or in loopback), oe=en_q.
  - CTS pad input is 2-flop synchronised to io_uart_cts_n.
  - In loopback, io_uart_cts_n = registered rts_n. When disabled, io_uart_cts_n = 1.
  - Latency: CTS pad -> io_uart_cts_n = 2 cycles.
- Macro undefined: these ports and their logic are absent.

## Structure
- Package n101_uartpad_pkg holds:
  - pad idle constants (IDLE_LVL=1);
  - pad reset values;
  - parameter defaults;
  - the pad-control struct typedef {oval, oe, ie, pue, ds}.
- One sub-module, n101_uartpad_rxfilt (synchroniser + glitch filter + break counter), instantiated CHANNELS times via generate.

## Test plan
- Reset, then io_en=2'b11, pad RX held 1 -> after 1 cycle TX oe=1 and RX ie=1; io_uart_rxd stays 1; io_rx_break=0.
- FILT_CYCLES=4: RX pad low for 3 cycles -> io_uart_rxd never falls. RX pad low for 4 cycles -> io_uart_rxd falls exactly 6 cycles after the pad edge.
- Hold RX low -> io_rx_break rises 160 cycles after io_uart_rxd falls. Release RX -> io_rx_break clears 1 cycle after io_uart_rxd rises.
- Loopback on ch1, toggle io_uart_txd[1] -> io_uart_rxd[1] follows after 5 cycles. TX pad oval[1] stays 1; ch0 is unaffected.
- Drop io_en[0] mid-break -> the next cycle shows io_uart_rxd[0]=1, io_rx_break[0]=0, oe=0. Re-enable -> RX resumes with filter latency.
- With N101_UARTPAD_FLOWCTRL_EN: CTS pad 1->0 -> io_uart_cts_n falls after 2 cycles. In loopback, io_uart_rts_n=0 -> io_uart_cts_n=0 after 1 cycle.
